branch_ctrl: RTL and testbench

Branch control unit for the pd4 core. Sits beside the branch comparator in execute: decodes branch funct3 into the comparator's signed/unsigned select and taken condition, predicts fetch-stage branches from a 2-bit saturating branch history table (BHT), resolves predictions in execute, and issues a registered one-cycle flush/redirect on mispredict. Also keeps saturating branch and mispredict counters for performance reporting.

---
 rtl/branch_pkg.sv | 29 ++
 rtl/branch_bht.sv | 48 ++++
 rtl/branch_ctrl.sv | 115 +++++++++++
 tb/tb_branch_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared definitions for the branch control unit.
//   - funct3 encodings of the conditional branches
//   - 2-bit saturating counter encodings for the BHT
//   - FSM state type of branch_ctrl
//   - saturating 32-bit increment helper for the performance counters
package branch_pkg;

  localparam logic [2:0] BEQ  = 3'b000;
  localparam logic [2:0] BNE  = 3'b001;
  localparam logic [2:0] BLT  = 3'b100;
  localparam logic [2:0] BGE  = 3'b101;
  localparam logic [2:0] BLTU = 3'b110;
  localparam logic [2:0] BGEU = 3'b111;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_e;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/branch_bht.sv
// Branch history table: ENTRIES x 2-bit saturating counters.
// Ports:
//   clock, reset_n   - clock, synchronous active-low reset (all entries -> WNT)
//   rd_idx_i         - lookup index; rd_ctr_o is the combinational counter value
//   wr_en_i          - apply one saturating update at wr_idx_i this edge
//   wr_idx_i         - update index
//   wr_taken_i       - 1: count up toward ST, 0: count down toward SNT
// The read port has no write bypass: a same-index read sees the old value.
module branch_bht
  import branch_pkg::*;
#(
  parameter  int ENTRIES = 16,
  localparam int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic [1:0]       rd_ctr_o,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic             wr_taken_i
);

  logic [ENTRIES-1:0][1:0] ctr_q;
  logic [1:0]              cur;
  logic [1:0]              ctr_d;

  assign rd_ctr_o = ctr_q[rd_idx_i];
  assign cur      = ctr_q[wr_idx_i];

  always_comb begin
    ctr_d = cur;
    if (wr_taken_i) begin
      if (cur != ST)  ctr_d = cur + 2'd1;
    end else begin
      if (cur != SNT) ctr_d = cur - 2'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= WNT;
    end else if (wr_en_i) begin
      ctr_q[wr_idx_i] <= ctr_d;
    end
  end

endmodule

// File: rtl/branch_ctrl.sv
// Branch control unit for execute.
// Ports:
//   clock, reset_n            - clock, synchronous active-low reset
//   f_pc / f_pred_taken       - fetch-side BHT lookup (combinational prediction)
//   ex_valid, ex_is_branch,
//   ex_funct3, ex_pc,
//   ex_target, ex_pred_taken  - execute-stage branch and its fetch prediction
//   brun_sel                  - comparator select, 1 = unsigned
//   br_eq, br_lt              - comparator results
//   ex_taken                  - resolved outcome (combinational)
//   flush, redirect_pc        - registered one-cycle redirect on mispredict
//   br_count,
//   mispredict_count          - saturating performance counters
module branch_ctrl
  import branch_pkg::*;
#(
  parameter  int BHT_ENTRIES = 16,
  localparam int IDX_W       = $clog2(BHT_ENTRIES)
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] f_pc,
  output logic        f_pred_taken,
  input  logic        ex_valid,
  input  logic        ex_is_branch,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  output logic        brun_sel,
  input  logic        br_eq,
  input  logic        br_lt,
  output logic        ex_taken,
  output logic        flush,
  output logic [31:0] redirect_pc,
  output logic [31:0] br_count,
  output logic [31:0] mispredict_count
);

  state_e      state_q, state_d;
  logic        flush_q, flush_d;
  logic [31:0] redir_q, redir_d;
  logic [31:0] br_cnt_q, br_cnt_d;
  logic [31:0] mp_cnt_q, mp_cnt_d;

  logic        resolve, legal, cond, upd, mispred;
  logic [1:0]  rd_ctr;

  // Wrong-path instructions (FLUSH) and reset both mask the resolve.
  assign resolve = reset_n & (state_q == RUN) & ex_valid & ex_is_branch;
  assign legal   = (ex_funct3[2:1] != 2'b01);
  assign brun_sel = ex_funct3[1];

  always_comb begin
    cond = 1'b0;
    case (ex_funct3)
      BEQ:        cond = br_eq;
      BNE:        cond = ~br_eq;
      BLT, BLTU:  cond = br_lt;
      BGE, BGEU:  cond = ~br_lt;
      default:    cond = 1'b0;
    endcase
  end

  assign upd      = resolve & legal;
  assign ex_taken = upd & cond;
  assign mispred  = upd & (cond != ex_pred_taken);

  branch_bht #(.ENTRIES(BHT_ENTRIES)) u_bht (
    .clock      (clock),
    .reset_n    (reset_n),
    .rd_idx_i   (f_pc[IDX_W+1:2]),
    .rd_ctr_o   (rd_ctr),
    .wr_en_i    (upd),
    .wr_idx_i   (ex_pc[IDX_W+1:2]),
    .wr_taken_i (cond)
  );

  assign f_pred_taken = rd_ctr[1];

  logic unused_fpc;
  assign unused_fpc = ^{f_pc[31:IDX_W+2], f_pc[1:0]};

  always_comb begin
    // mispred can only fire in RUN, so FLUSH always falls back to RUN.
    state_d  = mispred ? FLUSH : RUN;
    flush_d  = mispred;
    redir_d  = redir_q;
    if (mispred) redir_d = cond ? ex_target : ex_pc + 32'd4;
    br_cnt_d = upd     ? sat_inc32(br_cnt_q) : br_cnt_q;
    mp_cnt_d = mispred ? sat_inc32(mp_cnt_q) : mp_cnt_q;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= RUN;
      flush_q  <= 1'b0;
      redir_q  <= 32'd0;
      br_cnt_q <= 32'd0;
      mp_cnt_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      flush_q  <= flush_d;
      redir_q  <= redir_d;
      br_cnt_q <= br_cnt_d;
      mp_cnt_q <= mp_cnt_d;
    end
  end

  assign flush            = flush_q;
  assign redirect_pc      = redir_q;
  assign br_count         = br_cnt_q;
  assign mispredict_count = mp_cnt_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Bench for branch_ctrl: a behavioural model checked every cycle on the
// falling edge, directed scenarios with literal expectations, then random traffic.
module tb_branch_ctrl;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] f_pc;
  logic        f_pred_taken;
  logic        ex_valid, ex_is_branch;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_pc, ex_target;
  logic        ex_pred_taken;
  logic        brun_sel;
  logic        br_eq, br_lt;
  logic        ex_taken;
  logic        flush;
  logic [31:0] redirect_pc, br_count, mispredict_count;

  branch_ctrl #(.BHT_ENTRIES(16)) dut (
    .clock(clock), .reset_n(reset_n), .f_pc(f_pc), .f_pred_taken(f_pred_taken),
    .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_funct3(ex_funct3),
    .ex_pc(ex_pc), .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
    .brun_sel(brun_sel), .br_eq(br_eq), .br_lt(br_lt), .ex_taken(ex_taken),
    .flush(flush), .redirect_pc(redirect_pc), .br_count(br_count),
    .mispredict_count(mispredict_count)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          bht [16];
  bit          m_in_flush, m_flush, armed;
  logic [31:0] m_redir;
  longint      m_br, m_mp;
  bit          preload_req = 0;

  initial begin
    int  f3, idx;
    bit  legal, cond, qual, exp_taken;
    armed = 0;
    forever begin
      @(negedge clock);
      if (preload_req) m_br = 64'hFFFF_FFFE;
      f3    = int'(ex_funct3);
      legal = !(f3 == 2 || f3 == 3);
      case (f3)
        0:       cond = br_eq;
        1:       cond = !br_eq;
        4, 6:    cond = br_lt;
        5, 7:    cond = !br_lt;
        default: cond = 0;
      endcase
      qual      = reset_n && !m_in_flush && ex_valid && ex_is_branch;
      exp_taken = qual && legal && cond;
      if (armed) begin
        chk("m_pred",  {31'd0, f_pred_taken}, {31'd0, bht[(f_pc >> 2) & 15] >= 2});
        chk("m_brun",  {31'd0, brun_sel}, {31'd0, (f3 == 2 || f3 == 3 || f3 == 6 || f3 == 7)});
        chk("m_taken", {31'd0, ex_taken}, {31'd0, exp_taken});
        chk("m_flush", {31'd0, flush}, {31'd0, m_flush});
        chk("m_redir", redirect_pc, m_redir);
        chk("m_brcnt", br_count, m_br[31:0]);
        chk("m_mpcnt", mispredict_count, m_mp[31:0]);
      end
      if (!reset_n) begin
        foreach (bht[i]) bht[i] = 1;
        m_in_flush = 0; m_flush = 0; m_redir = 0; m_br = 0; m_mp = 0;
        armed = 1;
      end else begin
        m_flush = 0; m_in_flush = 0;
        if (qual && legal) begin
          idx = int'((ex_pc >> 2) & 15);
          if (cond) bht[idx] = (bht[idx] == 3) ? 3 : bht[idx] + 1;
          else      bht[idx] = (bht[idx] == 0) ? 0 : bht[idx] - 1;
          if (m_br < 64'hFFFF_FFFF) m_br++;
          if (cond != ex_pred_taken) begin
            if (m_mp < 64'hFFFF_FFFF) m_mp++;
            m_flush = 1; m_in_flush = 1;
            m_redir = cond ? ex_target : ex_pc + 32'd4;
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    @(posedge clock); #1;
    ex_valid = 0; ex_is_branch = 0;
  endtask

  task automatic br(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] tgt,
                    input logic pred, input logic eq, input logic lt);
    @(posedge clock); #1;
    ex_valid = 1; ex_is_branch = 1; ex_funct3 = f3; ex_pc = pc;
    ex_target = tgt; ex_pred_taken = pred; br_eq = eq; br_lt = lt;
  endtask

  initial begin
    reset_n = 0; f_pc = 0; ex_valid = 0; ex_is_branch = 0; ex_funct3 = 0;
    ex_pc = 0; ex_target = 0; ex_pred_taken = 0; br_eq = 0; br_lt = 0;

    // Reset and first BEQ
    repeat (2) @(posedge clock);
    #1 reset_n = 1; f_pc = 32'h100;
    @(negedge clock);
    chk("rst_pred", {31'd0, f_pred_taken}, 32'd0);
    chk("rst_br",   br_count, 32'd0);
    chk("rst_mp",   mispredict_count, 32'd0);
    chk("rst_flush",{31'd0, flush}, 32'd0);
    br(3'b000, 32'h100, 32'h200, 0, 1, 0);
    @(negedge clock);
    chk("beq_taken", {31'd0, ex_taken}, 32'd1);
    idle();
    @(negedge clock);
    chk("beq_flush", {31'd0, flush}, 32'd1);
    chk("beq_redir", redirect_pc, 32'h200);
    chk("beq_br",    br_count, 32'd1);
    chk("beq_mp",    mispredict_count, 32'd1);
    chk("beq_pred",  {31'd0, f_pred_taken}, 32'd1);
    idle();
    @(negedge clock);
    chk("flush_drop", {31'd0, flush}, 32'd0);
    chk("redir_hold", redirect_pc, 32'h200);

    // funct3 sweep
    for (int f = 0; f < 8; f++)
      for (int c = 0; c < 4; c++) begin
        br(3'(f), 32'h180, 32'h80, 0, c[0], c[1]);
        @(negedge clock);
        if (f == 3 && c == 3) chk("illegal_taken", {31'd0, ex_taken}, 32'd0);
        if (f == 6 && c == 2) chk("bltu_taken", {31'd0, ex_taken}, 32'd1);
        idle();
      end

    // BHT saturation at idx 1
    f_pc = 32'h304;
    br(3'b000, 32'h304, 32'h400, 0, 1, 0);
    @(negedge clock);
    chk("sat_pre", {31'd0, f_pred_taken}, 32'd0);
    idle();
    @(negedge clock);
    chk("sat_up1", {31'd0, f_pred_taken}, 32'd1);
    repeat (3) begin br(3'b000, 32'h304, 32'h400, 1, 1, 0); idle(); end
    br(3'b000, 32'h304, 32'h400, 1, 0, 0);
    idle();
    @(negedge clock);
    chk("nt_redir", redirect_pc, 32'h308);
    chk("nt_pred1", {31'd0, f_pred_taken}, 32'd1);
    br(3'b000, 32'h304, 32'h400, 1, 0, 0);
    idle();
    @(negedge clock);
    chk("nt_pred2", {31'd0, f_pred_taken}, 32'd0);
    repeat (2) begin br(3'b000, 32'h304, 32'h400, 0, 0, 0); idle(); end
    br(3'b001, 32'hFFFF_FFFC, 32'h10, 1, 1, 0);
    idle();
    @(negedge clock);
    chk("wrap_redir", redirect_pc, 32'h0);
    chk("wrap_flush", {31'd0, flush}, 32'd1);

    // Wrong-path suppression
    idle();
    br(3'b101, 32'h500, 32'h900, 0, 0, 0);
    br(3'b000, 32'h600, 32'h700, 0, 1, 0);
    @(negedge clock);
    chk("wp_taken", {31'd0, ex_taken}, 32'd0);
    chk("wp_flush", {31'd0, flush}, 32'd1);
    br(3'b001, 32'h604, 32'h700, 1, 0, 0);
    @(negedge clock);
    chk("wp_next_taken", {31'd0, ex_taken}, 32'd1);
    idle();
    @(negedge clock);
    chk("wp_noflush", {31'd0, flush}, 32'd0);

    // Collision at idx 7
    f_pc = 32'h41C;
    br(3'b000, 32'h41C, 32'h0, 0, 1, 0);
    @(negedge clock);
    chk("coll_old", {31'd0, f_pred_taken}, 32'd0);
    idle();
    @(negedge clock);
    chk("coll_new", {31'd0, f_pred_taken}, 32'd1);

    // Counter saturation via preload
    idle();
    force dut.br_cnt_q = 32'hFFFF_FFFE;
    preload_req = 1;
    @(posedge clock); #1;
    release dut.br_cnt_q;
    preload_req = 0;
    repeat (2) br(3'b000, 32'h41C, 32'h0, 1, 1, 0);
    idle();
    @(negedge clock);
    chk("br_sat", br_count, 32'hFFFF_FFFF);

    // Reset during flush cycle
    br(3'b000, 32'h800, 32'h900, 1, 0, 0);
    @(posedge clock); #1;
    ex_valid = 0; reset_n = 0;
    @(negedge clock);
    chk("rf_flush_pre", {31'd0, flush}, 32'd1);
    br(3'b000, 32'h800, 32'h900, 1, 1, 0);
    reset_n = 1;
    @(negedge clock);
    chk("rf_flush", {31'd0, flush}, 32'd0);
    chk("rf_br",    br_count, 32'd0);
    chk("rf_mp",    mispredict_count, 32'd0);
    chk("rf_run",   {31'd0, ex_taken}, 32'd1);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      @(posedge clock); #1;
      reset_n       = ($urandom_range(0, 255) != 0);
      ex_valid      = ($urandom_range(0, 3) != 0);
      ex_is_branch  = ($urandom_range(0, 4) != 0);
      ex_funct3     = 3'($urandom_range(0, 7));
      ex_pc         = ($urandom_range(0, 7) == 0) ? $urandom : 32'h1000 + 4 * $urandom_range(0, 20);
      ex_target     = $urandom;
      ex_pred_taken = 1'($urandom_range(0, 1));
      br_eq         = 1'($urandom_range(0, 1));
      br_lt         = 1'($urandom_range(0, 1));
      f_pc          = ($urandom_range(0, 3) == 0) ? ex_pc : 32'h1000 + 4 * $urandom_range(0, 20);
    end
    idle();
    @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
